// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction-memory responder: fetch FSM states,
// word geometry and the address legality rule used by both fetch and load paths.
package mips_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_t;

    // A byte address names a stored word only when it is word-aligned and the
    // word index falls inside the array.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                     input int unsigned        depth_words);
        logic aligned;
        logic in_range;
        aligned  = (addr[1:0] == 2'b00);
        in_range = ({2'b00, addr[ADDR_W-1:2]} < depth_words);
        return aligned && in_range;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one combinational read
// port, so a write and a read of the same word on one edge observe the old word.
module imem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_idx,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_idx,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem_q [DEPTH_WORDS];

    // Contents are deliberately left out of any reset so a loaded program
    // survives a reset of the fetch logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: accepts one PC request at a time, waits a fixed
// number of cycles, then presents the stored word (or an error) until consumed.
module instr_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_error,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    fetch_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] rsp_instr_q, rsp_instr_d;
    logic               rsp_error_q, rsp_error_d;

    logic               load_ok;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_ok;
    logic [INSTR_W-1:0] rd_data;
    logic               capture;

    // With zero wait the response is captured on the accept edge itself, so
    // the read must look at the live request address while idle.
    assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign rd_ok   = addr_ok(rd_addr, DEPTH_WORDS);
    assign load_ok = load_en && addr_ok(load_addr, DEPTH_WORDS);

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (load_ok),
        .wr_idx  (load_addr[AW+1:2]),
        .wr_data (load_data),
        .rd_idx  (rd_addr[AW+1:2]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_instr_d = rsp_instr_q;
        rsp_error_d = rsp_error_q;
        capture     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Response payload is frozen from the edge entering RESP onward.
        if (capture) begin
            rsp_error_d = !rd_ok;
            rsp_instr_d = rd_ok ? rd_data : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_instr_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_instr = rsp_instr_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed and randomized checks of instr_mem_responder against a word-array
// reference model; two instances cover WAIT_CYCLES = 2 and WAIT_CYCLES = 0.
module tb_instr_mem_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_error, load_en;
    logic [31:0] req_addr, rsp_instr, load_addr, load_data;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_error0, load_en0;
    logic [31:0] req_addr0, rsp_instr0, load_addr0, load_data0;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_error(rsp_error),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    instr_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_instr(rsp_instr0),
        .rsp_error(rsp_error0),
        .load_en(load_en0), .load_addr(load_addr0), .load_data(load_data0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        if (exp_err(a)) return 32'h0;
        return model_mem[a[9:2]];
    endfunction

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
        if (!exp_err(a)) model_mem[a[9:2]] = d;
    endtask

    // One complete fetch on the WAIT_CYCLES = 2 instance; rsp_ready is held low
    // for 'hold' cycles once the response is up, while req_addr wanders.
    task automatic fetch(input string tag, input logic [31:0] a, input int hold);
        int          edges;
        logic [31:0] ei;
        logic        ee;
        ei = exp_data(a);
        ee = exp_err(a);
        check($sformatf("%s/req_ready_idle", tag), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        edges     = 1;
        req_valid = 1'b0;
        while (!rsp_valid && edges < 20) begin
            req_addr  = $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            edges++;
        end
        rsp_ready = 1'b0;
        check($sformatf("%s/latency", tag), 32'(edges), 32'(W + 1));
        check($sformatf("%s/instr", tag), rsp_instr, ei);
        check($sformatf("%s/error", tag), 32'(rsp_error), 32'(ee));
        check($sformatf("%s/req_ready_busy", tag), 32'(req_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            req_addr = $urandom;
            tick();
            check($sformatf("%s/hold_valid", tag), 32'(rsp_valid), 32'd1);
            check($sformatf("%s/hold_instr", tag), rsp_instr, ei);
            check($sformatf("%s/hold_error", tag), 32'(rsp_error), 32'(ee));
            check($sformatf("%s/hold_ready", tag), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check($sformatf("%s/done_valid", tag), 32'(rsp_valid), 32'd0);
        check($sformatf("%s/done_ready", tag), 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;

        reset = 1'b0;
        req_valid = 0; req_addr = 0; rsp_ready = 0; load_en = 0; load_addr = 0; load_data = 0;
        req_valid0 = 0; req_addr0 = 0; rsp_ready0 = 0; load_en0 = 0; load_addr0 = 0; load_data0 = 0;
        #12;
        check("rst/req_ready", 32'(req_ready), 32'd1);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_instr", rsp_instr, 32'h0);
        check("rst/rsp_error", 32'(rsp_error), 32'd0);
        reset = 1'b1;

        // First edge after release must already accept a request.
        fetch("first_misaligned", 32'h2, 0);

        for (int i = 0; i < DEPTH; i++) do_load(32'(i) << 2, $urandom);

        do_load(32'h0, 32'h2008_0005);
        fetch("basic_0x0", 32'h0, 0);
        fetch("err_0x2", 32'h2, 0);
        fetch("err_0x400", 32'h400, 0);
        fetch("stall5", 32'h0, 5);

        // Load ignored when misaligned or out of range.
        do_load(32'h1, 32'hBAD0_0001);
        do_load(32'h400, 32'hBAD0_0400);
        fetch("ignored_load", 32'h0, 1);

        // Reset pulse in the middle of WAIT.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst/req_ready", 32'(req_ready), 32'd1);
        check("midrst/rsp_instr", rsp_instr, 32'h0);
        check("midrst/rsp_error", 32'(rsp_error), 32'd0);
        #2 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("midrst/no_rsp", 32'(rsp_valid), 32'd0);
        end
        fetch("after_rst_0x0", 32'h0, 1);

        // Load lands on the same edge that captures the response: old word.
        do_load(32'h8, 32'h1111_2222);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        model_mem[2] = 32'hDEAD_BEEF;
        check("same_edge/valid", 32'(rsp_valid), 32'd1);
        check("same_edge/instr", rsp_instr, 32'h1111_2222);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        fetch("refetch_0x8", 32'h8, 0);

        // Load one edge earlier than the capture: new word.
        do_load(32'hC, 32'h3333_4444);
        req_valid = 1'b1;
        req_addr  = 32'hC;
        tick();
        req_valid = 1'b0;
        load_en = 1'b1; load_addr = 32'hC; load_data = 32'h5555_6666;
        tick();
        load_en = 1'b0;
        model_mem[3] = 32'h5555_6666;
        tick();
        check("early_load/valid", 32'(rsp_valid), 32'd1);
        check("early_load/instr", rsp_instr, 32'h5555_6666);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Zero-wait instance.
        load_en0 = 1'b1; load_addr0 = 32'h4; load_data0 = 32'h8C09_0004;
        tick();
        load_en0 = 1'b0;
        check("w0/req_ready", 32'(req_ready0), 32'd1);
        req_valid0 = 1'b1;
        req_addr0  = 32'h4;
        tick();
        req_valid0 = 1'b0;
        req_addr0  = 32'h0;
        check("w0/valid", 32'(rsp_valid0), 32'd1);
        check("w0/instr", rsp_instr0, 32'h8C09_0004);
        check("w0/error", 32'(rsp_error0), 32'd0);
        check("w0/busy", 32'(req_ready0), 32'd0);
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        check("w0/done", 32'(rsp_valid0), 32'd0);
        req_valid0 = 1'b1;
        req_addr0  = 32'h6;
        tick();
        req_valid0 = 1'b0;
        check("w0/err_valid", 32'(rsp_valid0), 32'd1);
        check("w0/err_flag", 32'(rsp_error0), 32'd1);
        check("w0/err_instr", rsp_instr0, 32'h0);
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;

        // Randomized mix of loads and fetches.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else             a = $urandom;
            if ($urandom_range(0, 2) == 0) do_load(a, $urandom);
            else                           fetch("rand", a, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, number of 32-bit instruction words stored.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2, added fetch latency in clock cycles (range 0..15).
REQ-003 SHALL provide port clk  input  1  single system clock, all state updates on the rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous active-low reset; 0 = reset, 1 = run.
REQ-005 SHALL provide port req_valid  input  1  fetch request from the PC/fetch side.
REQ-006 SHALL provide port req_ready  output  1  responder can accept a request.
REQ-007 SHALL provide port req_addr  input  32  byte address of the instruction (current PC).
REQ-008 SHALL provide port rsp_valid  output  1  rsp_instr/rsp_error are valid.
REQ-009 SHALL provide port rsp_ready  input  1  consumer (instruction register) accepts the response.
REQ-010 SHALL provide port rsp_instr  output  32  fetched instruction word.
REQ-011 SHALL provide port rsp_error  output  1  request was misaligned or out of range.
REQ-012 SHALL provide port load_en  input  1  program-load write strobe.
REQ-013 SHALL provide port load_addr  input  32  byte address for program load.
REQ-014 SHALL provide port load_data  input  32  word written on load.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE (combinational from state).
REQ-016 Accept = req_valid & req_ready at a rising edge; req_addr captured into an internal address register at that edge.
REQ-017 On accept: WAIT_CYCLES = 0 -> RESP directly; else -> WAIT with counter loaded to WAIT_CYCLES-1.
REQ-018 In WAIT: counter decrements each edge; at counter = 0 the next edge enters RESP.
REQ-019 rsp_valid SHALL rise exactly WAIT_CYCLES+1 rising edges after the accept edge (inclusive of the accept edge) and equal 1 only in RESP.
REQ-020 rsp_instr/rsp_error SHALL be registered on the edge entering RESP and SHALL remain stable while rsp_valid = 1.
REQ-021 Word index = captured addr[31:2]; error when addr[1:0] != 0 or index >= DEPTH_WORDS; on error rsp_instr = 0, rsp_error = 1, same latency.
REQ-022 In RESP: rsp_ready = 1 at an edge -> IDLE, rsp_valid falls; rsp_ready = 0 -> hold RESP indefinitely.
REQ-023 No back-to-back overlap: a new request is accepted at the earliest on the edge after the one leaving RESP.
REQ-024 req_addr changes after the accept edge SHALL NOT affect the pending response.
REQ-025 load_en = 1 at an edge writes load_data to word load_addr[31:2] in any state; misaligned or out-of-range loads ignored.
REQ-026 Load and read-capture to the same word on the same edge: response returns the old word; load on an earlier edge: response returns the new word.
REQ-027 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-028 reset = 0 SHALL asynchronously force state IDLE, counter 0, rsp_valid 0, rsp_instr 0, rsp_error 0, address register 0; req_ready = 1 as a consequence of IDLE.
REQ-029 Reset mid-fetch (WAIT or RESP) SHALL abandon the request; no response is produced after reset release.
REQ-030 Memory array contents SHALL NOT be cleared by reset.
REQ-031 First accept possible on the first rising edge with reset = 1.

Structure
REQ-032 Shared package mips_mem_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP), WORD_BYTES = 4, and the instruction width constant 32.
REQ-033 Storage SHALL be a sub-module imem_array (one synchronous write port, one read port, DEPTH_WORDS x 32); FSM, counter and range check stay in instr_mem_responder.

Verification
REQ-034 Load word 0x20080005 at 0x0, WAIT_CYCLES = 2, request 0x0 with rsp_ready = 1 -> rsp_valid rises 3 edges after the accept edge, rsp_instr = 0x20080005, rsp_error = 0, returns to IDLE next edge.
REQ-035 WAIT_CYCLES = 0, request 0x4 holding word 0x8C090004 -> rsp_valid after the accept edge, data 0x8C090004.
REQ-036 Request 0x2 and request 0x400 (DEPTH_WORDS = 256) -> rsp_error = 1, rsp_instr = 0, same latency as a valid fetch.
REQ-037 rsp_ready held 0 for 5 cycles in RESP while req_addr toggles -> rsp_valid and rsp_instr stable, req_ready = 0 throughout.
REQ-038 reset pulsed low during WAIT -> immediately rsp_valid = 0, req_ready = 1; no response after release; memory word at 0x0 still 0x20080005.
REQ-039 Load 0xDEADBEEF to 0x8 on the same edge the fetch of 0x8 enters RESP -> old word returned; repeated fetch -> 0xDEADBEEF.
